imem_port_arbiter: RTL and testbench

//  Shares the single byte-wide instruction/data memory port between the variable-length fetch unit
//  and the memory-stage load/store path. Serialises 1/2/4-byte data accesses into byte beats and

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/byte_lane_assembler.sv | 49 ++++
 rtl/imem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: access size,
// arbiter state, and the size-to-beat-count helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_H  = 2'd1,
    SZ_W  = 2'd2,
    SZ_W2 = 2'd3
  } mem_size_e;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DATA  = 1'b1
  } arb_state_e;

  // Number of byte beats for an access; size code 3 behaves as a word.
  function automatic logic [2:0] beats(input mem_size_e sz);
    case (sz)
      SZ_B:    beats = 3'd1;
      SZ_H:    beats = 3'd2;
      default: beats = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_assembler.sv
// Collects read bytes of a multi-beat load into a little-endian word.
// Earlier beats sit in rbuf; the current beat's byte is inserted live so the
// full word is visible in the final-beat cycle. Lanes beyond the access size
// read as zero.
module byte_lane_assembler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        lane,
  input  logic [2:0]        nbeats,
  input  logic [7:0]        byte_in,
  input  logic              capture,
  input  logic              clear,
  output logic [DATA_W-1:0] word_out
);

  localparam int NL = DATA_W / 8;

  logic [DATA_W-9:0] rbuf;
  logic [DATA_W-1:0] rbuf_ext;

  assign rbuf_ext = {8'h00, rbuf};

  // Hold bytes of non-final beats; cleared when the access completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbuf <= '0;
    end else if (clear) begin
      rbuf <= '0;
    end else if (capture) begin
      for (int k = 0; k < NL - 1; k++) begin
        if (int'(lane) == k) rbuf[8*k +: 8] <= byte_in;
      end
    end
  end

  // Merge the live byte into its lane, keep buffered lanes, zero the rest.
  always_comb begin
    word_out = '0;
    for (int k = 0; k < NL; k++) begin
      if (k < int'(nbeats)) begin
        if (k == int'(lane)) word_out[8*k +: 8] = byte_in;
        else                 word_out[8*k +: 8] = rbuf_ext[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single byte-wide memory port between the fetch unit and the
// memory-stage load/store path. Data accesses are split into byte beats and
// may only take the port when fetch is idle or at an instruction boundary.
// Optional feature macro: IMEM_ARB_RR_EN (after a data access, let fetch
// complete one whole instruction before the next data access may start).
module imem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_at_start,
  input  logic              f_inst_end,
  output logic              f_grant,
  output logic [7:0]        f_rdata,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [1:0]        m_size,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_done,
  output logic              m_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  arb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              owe_fetch;
  logic              start, last;
  logic [1:0]        beat;
  logic [2:0]        nbeats;
  logic [DATA_W-1:0] asm_word;

  assign nbeats = beats(mem_size_e'(m_size));

  // Data may claim the port only from fetch mode, when fetch is idle or at an
  // instruction boundary, and fetch is not owed an instruction. Gating with
  // resetn keeps the port with fetch while reset is held.
  assign start  = resetn && (state_q == S_FETCH) && m_req &&
                  (!f_req || f_at_start) && !owe_fetch;
  assign m_busy = resetn && (start || (state_q == S_DATA));
  assign beat   = start ? 2'd0 : cnt_q;
  assign last   = ({1'b0, beat} == (nbeats - 3'd1));
  assign m_done = m_busy && last;

  assign f_rdata = mem_rdata;

  // Beat counter and owner state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance one beat per busy cycle, return to fetch after last.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (m_busy) begin
      if (last) begin
        state_d = S_FETCH;
        cnt_d   = 2'd0;
      end else begin
        state_d = S_DATA;
        cnt_d   = beat + 2'd1;
      end
    end
  end

  // Memory port mux: data beat when busy, otherwise fetch.
  always_comb begin
    f_grant   = f_req && !m_busy;
    mem_addr  = f_addr;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (m_busy) begin
      mem_addr  = m_addr + ADDR_W'(beat);
      mem_we    = m_we;
      mem_wdata = m_wdata[8*beat +: 8];
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Fetch is owed the port after a data access it was waiting on, until it
  // finishes an instruction or stops requesting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owe_fetch <= 1'b0;
    end else if (m_done) begin
      owe_fetch <= f_req;
    end else if (f_inst_end || !f_req) begin
      owe_fetch <= 1'b0;
    end
  end
`else
  logic unused_inst_end;
  assign unused_inst_end = f_inst_end;
  assign owe_fetch       = 1'b0;
`endif

  byte_lane_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk      (clk),
    .resetn   (resetn),
    .lane     (beat),
    .nbeats   (nbeats),
    .byte_in  (mem_rdata),
    .capture  (m_busy && !last),
    .clear    (m_done),
    .word_out (asm_word)
  );

  assign m_rdata = (m_done && !m_we) ? asm_word : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: a 4 KiB byte memory model (address
// aliased on the low 12 bits) sits behind the port. Inputs change on the
// falling edge; outputs are checked 1 time unit later, well before the
// next rising edge.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        f_req, f_at_start, f_inst_end, f_grant;
  logic [31:0] f_addr;
  logic [7:0]  f_rdata;
  logic        m_req, m_we, m_done, m_busy;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic [7:0]  mem [0:4095] = '{default: 8'h00};
  logic        pl_we = 1'b0;
  logic [11:0] pl_a  = 12'h000;
  logic [7:0]  pl_d  = 8'h00;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    if (pl_we)  mem[pl_a] <= pl_d;
  end

  assign mem_rdata = mem[mem_addr[11:0]];

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_at_start (f_at_start),
    .f_inst_end (f_inst_end),
    .f_grant    (f_grant),
    .f_rdata    (f_rdata),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_size     (m_size),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_done     (m_done),
    .m_busy     (m_busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    f_req = 0; f_addr = 0; f_at_start = 0; f_inst_end = 0;
    m_req = 0; m_we = 0; m_size = 0; m_addr = 0; m_wdata = 0;

    // Memory image loaded while the DUT is held in reset.
    for (int i = 0; i < 4; i++) preload(12'h100 + 12'(i), 8'hA0 + 8'(i));
    preload(12'h200, 8'h11);
    preload(12'h201, 8'h22);
    preload(12'h202, 8'h33);
    preload(12'h203, 8'h44);
    preload(12'h210, 8'h7F);
    preload(12'h211, 8'h5A);
    @(negedge clk);
    pl_we = 1'b0;

    // Reset: a pending data request must not take the port.
    f_req = 1; f_at_start = 1; m_req = 1; m_we = 1; m_size = 2; m_addr = 32'h200;
    #1;
    chk("rst_f_grant", f_grant, 1);
    chk("rst_m_busy",  m_busy,  0);
    chk("rst_m_done",  m_done,  0);
    chk("rst_mem_we",  mem_we,  0);

    @(negedge clk);
    resetn = 1'b1;
    m_req = 0; m_we = 0; m_size = 0;

    // 1: fetch only.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      f_req = 1; f_at_start = (i == 0); f_addr = 32'h100 + 32'(i);
      #1;
      chk("t1_f_grant",  f_grant,  1);
      chk("t1_mem_addr", mem_addr, 32'h100 + 32'(i));
      chk("t1_mem_we",   mem_we,   0);
      chk("t1_f_rdata",  f_rdata,  32'hA0 + 32'(i));
    end

    // 2: load word @0x200, fetch idle.
    @(negedge clk);
    f_req = 0; f_at_start = 0;
    m_req = 1; m_we = 0; m_size = 2; m_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("t2_m_busy",   m_busy,   1);
      chk("t2_mem_addr", mem_addr, 32'h200 + 32'(i));
      chk("t2_m_done",   m_done,   (i == 3) ? 1 : 0);
      chk("t2_f_grant",  f_grant,  0);
    end
    chk("t2_m_rdata", m_rdata, 32'h44332211);
    @(negedge clk);
    m_req = 0;
    #1;
    chk("t2_idle_busy", m_busy, 0);

    // 3: store half 0xBEEF @0x2FF, then @0xFFFFFFFF (address wrap).
    @(negedge clk);
    m_req = 1; m_we = 1; m_size = 1; m_addr = 32'h2FF; m_wdata = 32'h0000BEEF;
    #1;
    chk("t3_b0_addr",  mem_addr,  32'h2FF);
    chk("t3_b0_wdata", mem_wdata, 8'hEF);
    chk("t3_b0_we",    mem_we,    1);
    chk("t3_b0_done",  m_done,    0);
    @(negedge clk);
    #1;
    chk("t3_b1_addr",  mem_addr,  32'h300);
    chk("t3_b1_wdata", mem_wdata, 8'hBE);
    chk("t3_b1_we",    mem_we,    1);
    chk("t3_b1_done",  m_done,    1);
    chk("t3_b1_rdata", m_rdata,   0);
    @(negedge clk);
    m_addr = 32'hFFFF_FFFF;
    #1;
    chk("t3_mem_2ff", mem[12'h2FF], 8'hEF);
    chk("t3_mem_300", mem[12'h300], 8'hBE);
    chk("t3_w0_addr", mem_addr, 32'hFFFF_FFFF);
    chk("t3_w0_wdata", mem_wdata, 8'hEF);
    @(negedge clk);
    #1;
    chk("t3_w1_addr", mem_addr, 32'h0000_0000);
    chk("t3_w1_wdata", mem_wdata, 8'hBE);
    chk("t3_w1_done", m_done, 1);
    @(negedge clk);
    m_req = 0; m_we = 0;
    #1;
    chk("t3_mem_fff", mem[12'hFFF], 8'hEF);
    chk("t3_mem_000", mem[12'h000], 8'hBE);

    // 4: data waits while fetch is mid-instruction, starts at the boundary.
    @(negedge clk);
    f_req = 1; f_at_start = 0; f_addr = 32'h104;
    m_req = 1; m_we = 0; m_size = 0; m_addr = 32'h210;
    #1;
    chk("t4_wait0_grant", f_grant, 1);
    chk("t4_wait0_busy",  m_busy,  0);
    chk("t4_wait0_addr",  mem_addr, 32'h104);
    @(negedge clk);
    f_addr = 32'h105;
    #1;
    chk("t4_wait1_grant", f_grant, 1);
    chk("t4_wait1_busy",  m_busy,  0);
    @(negedge clk);
    f_at_start = 1; f_addr = 32'h106;
    #1;
    chk("t4_busy",  m_busy,   1);
    chk("t4_grant", f_grant,  0);
    chk("t4_done",  m_done,   1);
    chk("t4_rdata", m_rdata,  32'h0000007F);
    chk("t4_addr",  mem_addr, 32'h210);

    // 5: back-to-back data request while fetch keeps asking at a boundary.
    @(negedge clk);
    m_addr = 32'h211;
    #1;
`ifdef IMEM_ARB_RR_EN
    chk("t5_owed_busy",  m_busy,  0);
    chk("t5_owed_grant", f_grant, 1);
    @(negedge clk);
    f_at_start = 0; f_addr = 32'h107;
    #1;
    chk("t5_mid_busy",  m_busy,  0);
    chk("t5_mid_grant", f_grant, 1);
    @(negedge clk);
    f_inst_end = 1; f_addr = 32'h108;
    #1;
    chk("t5_end_busy",  m_busy,  0);
    chk("t5_end_grant", f_grant, 1);
    @(negedge clk);
    f_inst_end = 0; f_at_start = 1; f_addr = 32'h109;
    #1;
    chk("t5_next_busy",  m_busy,  1);
    chk("t5_next_done",  m_done,  1);
    chk("t5_next_rdata", m_rdata, 32'h0000005A);
`else
    chk("t5_b2b_busy",  m_busy,  1);
    chk("t5_b2b_grant", f_grant, 0);
    chk("t5_b2b_rdata", m_rdata, 32'h0000005A);
    @(negedge clk);
    m_addr = 32'h210; f_at_start = 0; f_addr = 32'h107;
    #1;
    chk("t5_mid_busy",  m_busy,  0);
    chk("t5_mid_grant", f_grant, 1);
    @(negedge clk);
    f_at_start = 1; f_addr = 32'h108;
    #1;
    chk("t5_next_busy",  m_busy,  1);
    chk("t5_next_rdata", m_rdata, 32'h0000007F);
`endif
    @(negedge clk);
    m_req = 0; f_req = 0; f_at_start = 0;

    // 6: reset during beat 1 of a word store.
    @(negedge clk);
    m_req = 1; m_we = 1; m_size = 2; m_addr = 32'h220; m_wdata = 32'hCAFEF00D;
    #1;
    chk("t6_b0_busy",  m_busy,    1);
    chk("t6_b0_wdata", mem_wdata, 8'h0D);
    @(negedge clk);
    #1;
    chk("t6_b1_addr",  mem_addr,  32'h221);
    chk("t6_b1_wdata", mem_wdata, 8'hF0);
    f_req = 1; f_addr = 32'h100;
    resetn = 1'b0;
    #1;
    chk("t6_rst_busy",  m_busy,  0);
    chk("t6_rst_done",  m_done,  0);
    chk("t6_rst_we",    mem_we,  0);
    chk("t6_rst_grant", f_grant, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("t6_hold_done", m_done, 0);
      chk("t6_hold_busy", m_busy, 0);
    end
    @(negedge clk);
    resetn = 1'b1; m_req = 0; m_we = 0;
    #1;
    chk("t6_rel_grant", f_grant,  1);
    chk("t6_rel_busy",  m_busy,   0);
    chk("t6_rel_addr",  mem_addr, 32'h100);
    chk("t6_rel_done",  m_done,   0);
    @(negedge clk);
    #1;
    chk("t6_mem_220", mem[12'h220], 8'h0D);
    chk("t6_mem_221", mem[12'h221], 8'h00);
    chk("t6_post_grant", f_grant, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
